// File: rtl/datapath_sequencer_pkg.sv
// Shared encodings for the datapath sequencer: RV32I-subset opcodes and function
// fields, ALU control codes, FSM states and instruction classes.
package datapath_sequencer_pkg;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERR
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE
  } iclass_t;

endpackage

// File: rtl/datapath_sequencer_instr_decode.sv
// Combinational instruction decoder: maps a 32-bit RV32I-subset word to register
// selects, ALU control, immediate, instruction class and an illegal flag.
module instr_decode
  import datapath_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4
) (
  input  logic [31:0]           instr,
  output logic [NAME_BITS-1:0]  rs1,
  output logic [NAME_BITS-1:0]  rs2,
  output logic [NAME_BITS-1:0]  ws,
  output logic [CTRL_BITS-1:0]  op,
  output logic                  imm_e,
  output logic [DATA_WIDTH-1:0] imm_d,
  output iclass_t               cls,
  output logic                  illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic [3:0]  alu;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign rs1   = NAME_BITS'(instr[19:15]);
  assign rs2   = NAME_BITS'(instr[24:20]);
  assign ws    = NAME_BITS'(instr[11:7]);
  assign op    = CTRL_BITS'(alu);
  assign imm_d = {{(DATA_WIDTH-12){imm12[11]}}, imm12};

  always_comb begin
    cls     = CLS_ALU_R;
    alu     = ALU_ADD;
    imm12   = '0;
    imm_e   = 1'b0;
    illegal = 1'b1;
    case (opcode)
      OPC_R: begin
        cls = CLS_ALU_R;
        if (funct7 == F7_BASE) begin
          illegal = 1'b0;
          case (funct3)
            F3_ADD:  alu = ALU_ADD;
            F3_SLT:  alu = ALU_SLT;
            F3_OR:   alu = ALU_OR;
            F3_AND:  alu = ALU_AND;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
          illegal = 1'b0;
          alu     = ALU_SUB;
        end
      end
      OPC_I: begin
        cls     = CLS_ALU_I;
        imm_e   = 1'b1;
        imm12   = instr[31:20];
        illegal = 1'b0;
        case (funct3)
          F3_ADD:  alu = ALU_ADD;
          F3_SLT:  alu = ALU_SLT;
          F3_OR:   alu = ALU_OR;
          F3_AND:  alu = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        cls   = CLS_LOAD;
        imm_e = 1'b1;
        imm12 = instr[31:20];
        if (funct3 == F3_WORD) illegal = 1'b0;
      end
      OPC_STORE: begin
        cls   = CLS_STORE;
        imm_e = 1'b1;
        imm12 = {instr[31:25], instr[11:7]};
        if (funct3 == F3_WORD) illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM: accepts one instruction per handshake, registers its
// decoded fields, and drives register-file / memory strobes through EXEC/MEM/WB.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NAME_BITS  = 5,
  parameter int CTRL_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [NAME_BITS-1:0]  rs1,
  output logic [NAME_BITS-1:0]  rs2,
  output logic [NAME_BITS-1:0]  ws,
  output logic [CTRL_BITS-1:0]  op,
  output logic                  imm_e,
  output logic [DATA_WIDTH-1:0] imm_d,
  output logic                  rf_we,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic                  done,
  output logic                  illegal
);

  state_t  state, state_nx;
  iclass_t cls_q;
  logic [31:0] instr_q;

  logic [NAME_BITS-1:0]  d_rs1, d_rs2, d_ws;
  logic [CTRL_BITS-1:0]  d_op;
  logic                  d_imm_e;
  logic [DATA_WIDTH-1:0] d_imm_d;
  iclass_t               d_cls;
  logic                  d_illegal;

  instr_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .NAME_BITS  (NAME_BITS),
    .CTRL_BITS  (CTRL_BITS)
  ) u_decode (
    .instr   (instr_q),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .ws      (d_ws),
    .op      (d_op),
    .imm_e   (d_imm_e),
    .imm_d   (d_imm_d),
    .cls     (d_cls),
    .illegal (d_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             instr_q <= '0;
    else if (state == ST_IDLE && instr_valid) instr_q <= instr;
  end

  // Illegal instructions leave the previously registered fields untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1   <= '0;
      rs2   <= '0;
      ws    <= '0;
      op    <= '0;
      imm_e <= 1'b0;
      imm_d <= '0;
      cls_q <= CLS_ALU_R;
    end else if (state == ST_DECODE && !d_illegal) begin
      rs1   <= d_rs1;
      rs2   <= d_rs2;
      ws    <= d_ws;
      op    <= d_op;
      imm_e <= d_imm_e;
      imm_d <= d_imm_d;
      cls_q <= d_cls;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (instr_valid) state_nx = ST_DECODE;
      ST_DECODE: state_nx = d_illegal ? ST_ERR : ST_EXEC;
      ST_EXEC:   state_nx = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? ST_MEM : ST_WB;
      ST_MEM:    state_nx = (cls_q == CLS_LOAD) ? ST_WB : ST_IDLE;
      ST_WB:     state_nx = ST_IDLE;
      ST_ERR:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Strobes depend only on registered state, so an async reset clears them at once.
  always_comb begin
    instr_ready = (state == ST_IDLE);
    rf_we       = (state == ST_WB) && (ws != '0);
    mem_re      = (cls_q == CLS_LOAD) && (state == ST_MEM || state == ST_WB);
    mem_we      = (cls_q == CLS_STORE) && (state == ST_MEM);
    done        = (state == ST_WB) || (state == ST_ERR) ||
                  (state == ST_MEM && cls_q == CLS_STORE);
    illegal     = (state == ST_ERR);
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: per-cycle strobe and field checks
// against hand-computed values for each supported instruction class.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs1, rs2, ws;
  logic [3:0]  op;
  logic        imm_e;
  logic [31:0] imm_d;
  logic        rf_we, mem_re, mem_we, done, illegal;

  int n_tests = 0;
  int n_fail  = 0;
  int waits;

  datapath_sequencer #(
    .DATA_WIDTH (32),
    .NAME_BITS  (5),
    .CTRL_BITS  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rs1         (rs1),
    .rs2         (rs2),
    .ws          (ws),
    .op          (op),
    .imm_e       (imm_e),
    .imm_d       (imm_d),
    .rf_we       (rf_we),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {instr_ready, rf_we, mem_re, mem_we, done, illegal}
  task automatic strb(input string tag, input logic [5:0] exp);
    chk(tag, {26'b0, instr_ready, rf_we, mem_re, mem_we, done, illegal}, {26'b0, exp});
  endtask

  task automatic issue(input logic [31:0] w, output int nwait);
    instr       = w;
    instr_valid = 1'b1;
    nwait       = 0;
    while (!instr_ready && nwait < 20) begin
      @(negedge clk);
      nwait++;
    end
    if (!instr_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      instr_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 instr_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    @(negedge clk);
    strb("reset_strobes", 6'b100000);
    chk("reset_fields", {rs1, rs2, ws, op, imm_e, 12'b0}, 32'd0);
    chk("reset_imm", imm_d, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADDI x1,x0,5
    issue(32'h00500093, waits);
    @(negedge clk); strb("addi_c1", 6'b000000);
    @(negedge clk); strb("addi_c2", 6'b000000);
    chk("addi_op", op, 32'h2);
    chk("addi_imm_e", imm_e, 32'h1);
    chk("addi_imm_d", imm_d, 32'd5);
    chk("addi_ws", ws, 32'd1);
    @(negedge clk); strb("addi_c3", 6'b010010);
    @(negedge clk); strb("addi_c4", 6'b100000);

    // SUB x4,x0,x3
    issue(32'h40300233, waits);
    @(negedge clk); @(negedge clk);
    chk("sub_op", op, 32'h6);
    chk("sub_imm_e", imm_e, 32'h0);
    chk("sub_rs1", rs1, 32'd0);
    chk("sub_rs2", rs2, 32'd3);
    chk("sub_ws", ws, 32'd4);
    chk("sub_imm_d", imm_d, 32'd0);
    @(negedge clk); strb("sub_c3", 6'b010010);
    @(negedge clk); strb("sub_c4", 6'b100000);

    // SLT x5,x0,x2
    issue(32'h002022B3, waits);
    @(negedge clk); @(negedge clk);
    chk("slt_op", op, 32'h7);
    chk("slt_ws", ws, 32'd5);
    chk("slt_rs2", rs2, 32'd2);
    @(negedge clk); strb("slt_c3", 6'b010010);
    @(negedge clk); strb("slt_c4", 6'b100000);

    // LW x2,8(x1)
    issue(32'h0080A103, waits);
    @(negedge clk); strb("lw_c1", 6'b000000);
    @(negedge clk); strb("lw_c2", 6'b000000);
    chk("lw_imm_d", imm_d, 32'd8);
    chk("lw_op", op, 32'h2);
    chk("lw_rs1", rs1, 32'd1);
    chk("lw_ws", ws, 32'd2);
    chk("lw_imm_e", imm_e, 32'h1);
    @(negedge clk); strb("lw_c3", 6'b001000);
    @(negedge clk); strb("lw_c4", 6'b011010);
    @(negedge clk); strb("lw_c5", 6'b100000);

    // SW x2,-4(x1)
    issue(32'hFE20AE23, waits);
    @(negedge clk); strb("sw_c1", 6'b000000);
    @(negedge clk); strb("sw_c2", 6'b000000);
    chk("sw_imm_d", imm_d, 32'hFFFFFFFC);
    chk("sw_op", op, 32'h2);
    chk("sw_rs1", rs1, 32'd1);
    chk("sw_rs2", rs2, 32'd2);
    @(negedge clk); strb("sw_c3", 6'b000110);
    @(negedge clk); strb("sw_c4", 6'b100000);

    // Illegal word, fields must keep the SW values
    issue(32'hFFFFFFFF, waits);
    @(negedge clk); strb("ill_c1", 6'b000000);
    @(negedge clk); strb("ill_c2", 6'b000011);
    chk("ill_imm_hold", imm_d, 32'hFFFFFFFC);
    chk("ill_op_hold", op, 32'h2);

    // ADD x0,x1,x2 offered back-to-back, accepted on the first IDLE cycle
    issue(32'h00208033, waits);
    chk("b2b_waits", waits, 32'd1);
    @(negedge clk); strb("add0_c1", 6'b000000);
    @(negedge clk);
    chk("add0_ws", ws, 32'd0);
    chk("add0_rs1", rs1, 32'd1);
    chk("add0_rs2", rs2, 32'd2);
    chk("add0_op", op, 32'h2);
    @(negedge clk); strb("add0_c3", 6'b000010);
    @(negedge clk); strb("add0_c4", 6'b100000);

    // ADD x3,x1,x2 interrupted by reset during WB
    issue(32'h002081B3, waits);
    @(negedge clk); @(negedge clk);
    @(negedge clk); strb("rst_wb_pre", 6'b010010);
    #2 rst_n = 1'b0;
    #1 strb("rst_async_strobes", 6'b100000);
    chk("rst_async_fields", {rs1, rs2, ws, op, imm_e, 12'b0}, 32'd0);
    @(negedge clk);
    strb("rst_held", 6'b100000);
    rst_n = 1'b1;
    @(negedge clk); strb("rst_after", 6'b100000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
